// File: rtl/aes_subbytes_engine_if.sv
// ---------------------------------------------------------------------------
// aes_subbytes_engine_if
//   Bundles the block-in / block-out handshakes of the SubBytes engine.
//
//   in_valid  : source -> engine, input block valid
//   in_ready  : engine -> source, engine can accept a block
//   in_data   : source -> engine, input state, byte i = in_data[8i+7:8i]
//   inv_mode  : source -> engine, 0 = forward S-box, 1 = inverse S-box
//   out_valid : engine -> sink,   result valid
//   out_ready : sink -> engine,   sink accepts the result
//   out_data  : engine -> sink,   substituted state
//   busy      : engine -> anyone, high while a block is in flight
//
//   master : the side that feeds blocks and consumes results
//   slave  : the engine itself
// ---------------------------------------------------------------------------
interface aes_subbytes_engine_if #(
  parameter int N_BYTES = 16
) ();

  logic                   in_valid;
  logic                   in_ready;
  logic [8*N_BYTES-1:0]   in_data;
  logic                   inv_mode;
  logic                   out_valid;
  logic                   out_ready;
  logic [8*N_BYTES-1:0]   out_data;
  logic                   busy;

  modport master (
    output in_valid, in_data, inv_mode, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, inv_mode, out_ready,
    output in_ready, out_valid, out_data, busy
  );

endinterface

// File: rtl/aes_subbytes_engine.sv
// ---------------------------------------------------------------------------
// aes_subbytes_engine
//   Multi-lane AES SubBytes engine. A 128-bit state is accepted over a
//   valid/ready handshake, LANES bytes are substituted per cycle in place
//   in a work register (forward or inverse S-box, chosen per block), and the
//   result is presented over a valid/ready handshake that holds under
//   backpressure. Sits between AddRoundKey and ShiftRows.
//
//   Parameters
//     N_BYTES : bytes per block (state width 8*N_BYTES)
//     LANES   : S-box lanes per cycle; 1,2,4,8 or 16 and must divide N_BYTES
//
//   Ports
//     clk : rising-edge clock
//     rst : asynchronous, active-low reset
//     bus : aes_subbytes_engine_if.slave (in_*/out_* handshakes, busy)
//
//   Latency: out_valid rises N_BYTES/LANES cycles after the accept edge.
//   Throughput: one block per N_BYTES/LANES + 2 cycles back to back.
// ---------------------------------------------------------------------------
module aes_subbytes_engine #(
  parameter int N_BYTES = 16,
  parameter int LANES   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  aes_subbytes_engine_if.slave  bus
);

  localparam int STEPS = N_BYTES / LANES;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SUB  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // FIPS-197 tables, entry 0 in the most significant byte. Entry b therefore
  // lives at bit offset (255-b)*8, which is simply {~b, 3'b000}.
  localparam logic [2047:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    return SBOX_FWD[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] b);
    return SBOX_INV[{~b, 3'b000} +: 8];
  endfunction

  logic [1:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [8*N_BYTES-1:0] work;
  logic                 mode;
  logic [7:0]           lane_out [LANES];

  // Lane l of step cnt handles byte cnt*LANES + l of the work register.
  // NOTE: every element is assigned on every pass, so no latch is inferred.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_out[l] = mode ? sbox_inv(work[(int'(cnt) * LANES + l) * 8 +: 8])
                         : sbox_fwd(work[(int'(cnt) * LANES + l) * 8 +: 8]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      // NOTE: the work register is reset on purpose: out_data must read 0
      // after reset and an aborted block must leave no residue.
      work  <= '0;
      mode  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            work  <= bus.in_data;
            mode  <= bus.inv_mode;
            cnt   <= '0;
            state <= S_SUB;
          end
        end
        S_SUB: begin
          for (int l = 0; l < LANES; l++) begin
            work[(int'(cnt) * LANES + l) * 8 +: 8] <= lane_out[l];
          end
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= S_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          // in_ready is low here, so a pending in_valid waits for IDLE.
          if (bus.out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.out_data  = work;

endmodule

// File: tb/tb_aes_subbytes_engine.sv
// ---------------------------------------------------------------------------
// tb_aes_subbytes_engine
//   Three engines (LANES = 1, 4, 16) share one stimulus set; sel routes the
//   handshake to one of them at a time. Expected results come from S-box
//   tables built here from GF(2^8) inversion plus the AES affine map, and
//   from known-answer constants.
// ---------------------------------------------------------------------------
module tb_aes_subbytes_engine;

  localparam int NB = 16;
  localparam logic [127:0] KAT_IN  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         inv_mode = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_data = '0;
  int           sel = 0;

  logic         o_valid, i_ready, o_busy;
  logic [127:0] o_data;

  int total = 0;
  int bad   = 0;

  logic [7:0]   fwd_tab [256];
  logic [7:0]   inv_tab [256];
  logic [127:0] exp_q [$];

  always #5 clk = ~clk;

  aes_subbytes_engine_if #(.N_BYTES(NB)) if_l1 ();
  aes_subbytes_engine_if #(.N_BYTES(NB)) if_l4 ();
  aes_subbytes_engine_if #(.N_BYTES(NB)) if_l16 ();

  assign if_l1.in_valid   = in_valid && (sel == 0);
  assign if_l1.in_data    = in_data;
  assign if_l1.inv_mode   = inv_mode;
  assign if_l1.out_ready  = out_ready && (sel == 0);
  assign if_l4.in_valid   = in_valid && (sel == 1);
  assign if_l4.in_data    = in_data;
  assign if_l4.inv_mode   = inv_mode;
  assign if_l4.out_ready  = out_ready && (sel == 1);
  assign if_l16.in_valid  = in_valid && (sel == 2);
  assign if_l16.in_data   = in_data;
  assign if_l16.inv_mode  = inv_mode;
  assign if_l16.out_ready = out_ready && (sel == 2);

  aes_subbytes_engine #(.N_BYTES(NB), .LANES(1))  dut_l1  (.clk(clk), .rst(rst), .bus(if_l1.slave));
  aes_subbytes_engine #(.N_BYTES(NB), .LANES(4))  dut_l4  (.clk(clk), .rst(rst), .bus(if_l4.slave));
  aes_subbytes_engine #(.N_BYTES(NB), .LANES(16)) dut_l16 (.clk(clk), .rst(rst), .bus(if_l16.slave));

  always_comb begin
    case (sel)
      1: begin
        o_valid = if_l4.out_valid; i_ready = if_l4.in_ready;
        o_busy  = if_l4.busy;      o_data  = if_l4.out_data;
      end
      2: begin
        o_valid = if_l16.out_valid; i_ready = if_l16.in_ready;
        o_busy  = if_l16.busy;      o_data  = if_l16.out_data;
      end
      default: begin
        o_valid = if_l1.out_valid; i_ready = if_l1.in_ready;
        o_busy  = if_l1.busy;      o_data  = if_l1.out_data;
      end
    endcase
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    if (a == 8'h00) return 8'h00;
    for (int c = 1; c < 256; c++) begin
      if (gmul(a, 8'(c)) == 8'h01) return 8'(c);
    end
    return 8'h00;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  task automatic build_tables();
    for (int i = 0; i < 256; i++) begin
      fwd_tab[i] = affine(ginv(8'(i)));
      inv_tab[fwd_tab[i]] = 8'(i);
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] d, input logic m);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) begin
      r[8*i +: 8] = m ? inv_tab[d[8*i +: 8]] : fwd_tab[d[8*i +: 8]];
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus helpers ----------------
  // Called on the first falling edge after the accept edge; cyc counts
  // rising edges since the accept edge when out_valid is first seen.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!o_valid && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_block(input string tag, input logic [127:0] d, input logic m,
                           input int lat, input bit early, output logic [127:0] got);
    int cyc;
    @(negedge clk);
    check({tag, "_in_ready"}, 128'(i_ready), 128'(1));
    in_valid = 1'b1; in_data = d; inv_mode = m; out_ready = early;
    @(negedge clk);
    in_valid = 1'b0; in_data = rand128(); inv_mode = ~m;
    check({tag, "_busy"}, 128'(o_busy), 128'(1));
    wait_valid(cyc);
    check({tag, "_latency"}, 128'(cyc), 128'(lat));
    got = o_data;
    check({tag, "_data"}, got, model(d, m));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 128'(o_valid), 128'(0));
    check({tag, "_idle_ready"}, 128'(i_ready), 128'(1));
  endtask

  task automatic stream(input string tag, input int n);
    int  sent = 0;
    int  rcv  = 0;
    int  cyc  = 0;
    bit  stop = 1'b0;
    exp_q.delete();
    fork
      begin
        while (sent < n && !stop) begin
          int           gap;
          logic [127:0] d;
          logic         m;
          gap = $urandom_range(0, 3);
          repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0; in_data = rand128(); inv_mode = 1'($urandom_range(0, 1));
          end
          @(negedge clk);
          d = rand128();
          m = 1'($urandom_range(0, 1));
          in_valid = 1'b1; in_data = d; inv_mode = m;
          while (!i_ready && !stop) @(negedge clk);
          if (!stop) begin
            exp_q.push_back(model(d, m));
            sent++;
          end
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        while (rcv < n && cyc < 20000) begin
          @(negedge clk);
          cyc++;
          out_ready = 1'($urandom_range(0, 1));
          if (o_valid && out_ready) begin
            if (exp_q.size() == 0) check({tag, "_extra"}, 128'(1), 128'(0));
            else check($sformatf("%s_blk%0d", tag, rcv), o_data, exp_q.pop_front());
            rcv++;
          end
        end
        stop = 1'b1;
        if (rcv < n) check({tag, "_timeout"}, 128'(rcv), 128'(n));
        @(negedge clk);
        out_ready = 1'b0;
      end
    join
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] got, got2, d1, d2, e1, e2;
    logic         m2;
    int           cyc, lat;
    bit           spurious;

    build_tables();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", 128'(o_valid), 128'(0));
    check("rst_in_ready",  128'(i_ready), 128'(1));
    check("rst_busy",      128'(o_busy),  128'(0));
    check("rst_out_data",  o_data, 128'h0);
    @(negedge clk);
    rst = 1'b1;

    // Known answers, forward then inverse, on every lane count
    for (int s = 0; s < 3; s++) begin
      sel = s;
      lat = (s == 0) ? 16 : (s == 1) ? 4 : 1;
      run_block($sformatf("kat_fwd_l%0d", s), KAT_IN, 1'b0, lat, 1'b0, got);
      check($sformatf("kat_fwd_const_l%0d", s), got, KAT_OUT);
      // out_ready held high through SUB on the last lane set
      run_block($sformatf("kat_inv_l%0d", s), got, 1'b1, lat, (s == 2), got2);
      check($sformatf("kat_inv_const_l%0d", s), got2, KAT_IN);
    end

    // All-zero block and single-byte 0x53
    sel = 0;
    run_block("zero", 128'h0, 1'b0, 16, 1'b1, got);
    check("zero_const", got, {16{8'h63}});
    run_block("b53", 128'h53, 1'b0, 16, 1'b0, got);
    check("b53_const", got, {{15{8'h63}}, 8'hed});

    // Backpressure: hold DONE for 10 cycles with a pending block
    d1 = rand128(); e1 = model(d1, 1'b0);
    d2 = rand128(); m2 = 1'b1; e2 = model(d2, m2);
    @(negedge clk);
    in_valid = 1'b1; in_data = d1; inv_mode = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(cyc);
    check("bp_latency", 128'(cyc), 128'(16));
    in_valid = 1'b1; in_data = d2; inv_mode = m2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold_valid%0d", i), 128'(o_valid), 128'(1));
      check($sformatf("bp_hold_data%0d", i),  o_data, e1);
      check($sformatf("bp_hold_ready%0d", i), 128'(i_ready), 128'(0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_valid", 128'(o_valid), 128'(0));
    check("bp_release_idle",  128'(o_busy),  128'(0));
    check("bp_release_ready", 128'(i_ready), 128'(1));
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_next_busy", 128'(o_busy), 128'(1));
    wait_valid(cyc);
    check("bp_next_latency", 128'(cyc), 128'(16));
    check("bp_next_data", o_data, e2);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset at cnt=7 of a LANES=1 block
    @(negedge clk);
    in_valid = 1'b1; in_data = rand128(); inv_mode = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_out_valid", 128'(o_valid), 128'(0));
    check("abort_in_ready",  128'(i_ready), 128'(1));
    check("abort_out_data",  o_data, 128'h0);
    @(negedge clk);
    rst = 1'b1;
    spurious = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (o_valid) spurious = 1'b1;
    end
    check("abort_no_output", 128'(spurious), 128'(0));
    d1 = rand128();
    run_block("post_abort", d1, 1'b1, 16, 1'b0, got);

    // Random streaming with gaps and backpressure on every lane count
    for (int s = 0; s < 3; s++) begin
      sel = s;
      stream($sformatf("stream_l%0d", s), 50);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
